// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and tag type for the multiplier tag pipe
package mul_pkg;

   localparam int RD_W_DEF       = 5;
   localparam int CNT_W_DEF      = 32;
   // Register boundaries in the multiplier datapath: EX->MEM and MEM->WB.
   localparam int MUL_REG_STAGES = 2;

   typedef struct packed {
      logic                valid;
      logic [RD_W_DEF-1:0] rd;
   } mul_tag_t;

endpackage

// File: rtl/mul_src_cmp.sv
// rtl/mul_src_cmp.sv - one decode source compared against the EX and MEM MUL tags
module mul_src_cmp
   import mul_pkg::*;
#(
   parameter int RD_W = RD_W_DEF
) (
   input  logic [RD_W-1:0] rs_i,
   input  logic            used_i,
   input  logic            ex_valid_i,
   input  logic [RD_W-1:0] ex_rd_i,
   input  logic            mem_valid_i,
   input  logic [RD_W-1:0] mem_rd_i,
   output logic            hazard_o
);

   logic ex_match;
   logic mem_match;

   assign ex_match  = ex_valid_i  & (ex_rd_i  == rs_i);
   assign mem_match = mem_valid_i & (mem_rd_i == rs_i);

   // A WB match is deliberately absent: the product is bypassed from WB.
   assign hazard_o = used_i & (rs_i != '0) & (ex_match | mem_match);

endmodule

// File: rtl/mul_tag_pipe.sv
// rtl/mul_tag_pipe.sv - MUL destination tag pipeline and interlock; optional MUL_PERF_CNT_EN counters
module mul_tag_pipe
   import mul_pkg::*;
#(
   parameter int RD_W  = RD_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            issue_valid,
   input  logic [RD_W-1:0] issue_rd,
   input  logic            flush_ex,
   input  logic [RD_W-1:0] id_rs1,
   input  logic [RD_W-1:0] id_rs2,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   output logic            mul_hazard,
   output logic            wb_valid,
   output logic [RD_W-1:0] wb_rd,
   output logic            wb_we,
   output logic            mul_busy
`ifdef MUL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_mul_issued,
   output logic [CNT_W-1:0] perf_mul_stall
`endif
);

   if (RD_W < 1 || CNT_W < 1) begin : g_bad_width
      $error("mul_tag_pipe: RD_W and CNT_W must be positive");
   end

   logic            ex_v;
   logic [RD_W-1:0] ex_rd;
   logic            mem_valid_q, mem_valid_d;
   logic [RD_W-1:0] mem_rd_q, mem_rd_d;
   logic            wb_valid_q, wb_valid_d;
   logic [RD_W-1:0] wb_rd_q, wb_rd_d;
   logic            hz_rs1;
   logic            hz_rs2;

   // The EX tag is qualified by rst_n so every output is quiet while reset is held.
   assign ex_v  = issue_valid & ~flush_ex & rst_n;
   assign ex_rd = issue_rd;

   always_comb begin
      mem_valid_d = mem_valid_q;
      mem_rd_d    = mem_rd_q;
      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      if (!stall) begin
         mem_valid_d = ex_v;
         mem_rd_d    = ex_rd;
         wb_valid_d  = mem_valid_q;
         wb_rd_d     = mem_rd_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
      end else begin
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
      end
   end

   mul_src_cmp #(.RD_W(RD_W)) u_cmp_rs1 (
      .rs_i        (id_rs1),
      .used_i      (id_rs1_used),
      .ex_valid_i  (ex_v),
      .ex_rd_i     (ex_rd),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .hazard_o    (hz_rs1)
   );

   mul_src_cmp #(.RD_W(RD_W)) u_cmp_rs2 (
      .rs_i        (id_rs2),
      .used_i      (id_rs2_used),
      .ex_valid_i  (ex_v),
      .ex_rd_i     (ex_rd),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .hazard_o    (hz_rs2)
   );

   assign mul_hazard = hz_rs1 | hz_rs2;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   // Write only in the cycle WB advances, so a stalled result is written once.
   assign wb_we      = wb_valid_q & ~stall & (wb_rd_q != '0);
   assign mul_busy   = ex_v | mem_valid_q | wb_valid_q;

`ifdef MUL_PERF_CNT_EN
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issued_d    = issued_q;
      stall_cnt_d = stall_cnt_q;
      if (ex_v && !stall) begin
         issued_d = issued_q + 1'b1;
      end
      if (mul_hazard && !stall) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         issued_q    <= issued_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_mul_issued = issued_q;
   assign perf_mul_stall  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_tag_pipe.sv
// tb/tb_mul_tag_pipe.sv - directed vector bench for mul_tag_pipe
module tb_mul_tag_pipe;
   import mul_pkg::*;

   localparam int RD_W  = 5;
   localparam int CNT_W = 32;
   localparam int NVEC  = 33;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            stall;
   logic            issue_valid;
   logic [RD_W-1:0] issue_rd;
   logic            flush_ex;
   logic [RD_W-1:0] id_rs1;
   logic [RD_W-1:0] id_rs2;
   logic            id_rs1_used;
   logic            id_rs2_used;
   logic            mul_hazard;
   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic            wb_we;
   logic            mul_busy;
`ifdef MUL_PERF_CNT_EN
   logic [CNT_W-1:0] perf_mul_issued;
   logic [CNT_W-1:0] perf_mul_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_tag_pipe #(.RD_W(RD_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .flush_ex    (flush_ex),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .mul_hazard  (mul_hazard),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_we       (wb_we),
      .mul_busy    (mul_busy)
`ifdef MUL_PERF_CNT_EN
      ,
      .perf_mul_issued (perf_mul_issued),
      .perf_mul_stall  (perf_mul_stall)
`endif
   );

   typedef struct {
      logic            st;
      logic            iv;
      logic [RD_W-1:0] ird;
      logic            fl;
      logic [RD_W-1:0] rs1;
      logic            u1;
      logic [RD_W-1:0] rs2;
      logic            u2;
      logic            hz;
      logic            wv;
      logic [RD_W-1:0] wrd;
      logic            we;
      logic            busy;
   } vec_t;

   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic st, input logic iv, input int ird, input logic fl,
                               input int rs1, input logic u1, input int rs2, input logic u2,
                               input logic hz, input logic wv, input int wrd, input logic we,
                               input logic busy);
      vec_t v;
      v.st = st;  v.iv = iv;  v.ird = RD_W'(ird);  v.fl = fl;
      v.rs1 = RD_W'(rs1);  v.u1 = u1;  v.rs2 = RD_W'(rs2);  v.u2 = u2;
      v.hz = hz;  v.wv = wv;  v.wrd = RD_W'(wrd);  v.we = we;  v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic iv, input int ird, input logic fl,
                        input int rs1, input logic u1, input int rs2, input logic u2);
      stall = st;  issue_valid = iv;  issue_rd = RD_W'(ird);  flush_ex = fl;
      id_rs1 = RD_W'(rs1);  id_rs1_used = u1;  id_rs2 = RD_W'(rs2);  id_rs2_used = u2;
   endtask

   task automatic check_outs(input string tag, input logic hz, input logic wv, input int wrd,
                             input logic we, input logic busy);
      chk({tag, " hazard"}, 32'(mul_hazard), 32'(hz));
      chk({tag, " wb_valid"}, 32'(wb_valid), 32'(wv));
      chk({tag, " wb_rd"}, 32'(wb_rd), 32'(wrd));
      chk({tag, " wb_we"}, 32'(wb_we), 32'(we));
      chk({tag, " busy"}, 32'(mul_busy), 32'(busy));
   endtask

   // Drive inputs just after a posedge, sample at the following negedge.
   task automatic cycle_end;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           st iv rd fl rs1 u1 rs2 u2 | hz wv wrd we busy
      tbl[0]  = mk(0, 1, 7, 0, 7, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[1]  = mk(0, 0, 0, 0, 7, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[2]  = mk(0, 0, 0, 0, 7, 1, 0, 0,   0, 1, 7, 1, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, 7, 0, 7, 0, 0, 0,   0, 0, 0, 0, 1);
      tbl[5]  = mk(0, 0, 0, 0, 7, 0, 0, 0,   0, 0, 0, 0, 1);
      tbl[6]  = mk(0, 0, 0, 0, 7, 0, 0, 0,   0, 1, 7, 1, 1);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[8]  = mk(0, 1, 3, 0, 3, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0, 0, 3, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[10] = mk(1, 0, 0, 0, 3, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[11] = mk(1, 0, 0, 0, 3, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[12] = mk(0, 0, 0, 0, 3, 1, 0, 0,   1, 0, 0, 0, 1);
      tbl[13] = mk(1, 0, 0, 0, 3, 1, 0, 0,   0, 1, 3, 0, 1);
      tbl[14] = mk(1, 0, 0, 0, 3, 1, 0, 0,   0, 1, 3, 0, 1);
      tbl[15] = mk(0, 0, 0, 0, 3, 1, 0, 0,   0, 1, 3, 1, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[17] = mk(0, 1, 9, 1, 0, 0, 9, 1,   0, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 9, 1,   0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 9, 0, 0);
      tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[21] = mk(1, 1, 9, 1, 0, 0, 9, 1,   0, 0, 0, 0, 0);
      tbl[22] = mk(0, 0, 0, 0, 0, 0, 9, 1,   0, 0, 0, 0, 0);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[24] = mk(0, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
      tbl[25] = mk(0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 1);
      tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1);
      tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
      tbl[28] = mk(0, 1, 4, 0, 0, 0, 4, 1,   1, 0, 0, 0, 1);
      tbl[29] = mk(0, 1, 4, 0, 0, 0, 4, 1,   1, 0, 0, 0, 1);
      tbl[30] = mk(0, 0, 0, 0, 0, 0, 4, 1,   1, 1, 4, 1, 1);
      tbl[31] = mk(0, 0, 0, 0, 0, 0, 4, 1,   0, 1, 4, 1, 1);
      tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

      // Reset held while an issue and a matching source are presented.
      rst_n = 1'b0;
      drive(0, 1, 5, 0, 5, 1, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("in_reset", 0, 0, 0, 0, 0);
`ifdef MUL_PERF_CNT_EN
      chk("in_reset perf_issued", perf_mul_issued, 0);
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b1;
      cycle_end();

      // First issue after reset reaches WB after MUL_REG_STAGES cycles.
      for (int c = 0; c <= MUL_REG_STAGES; c++) begin
         if (c == 0) drive(0, 1, 5, 0, 0, 0, 0, 0);
         else        drive(0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (c == MUL_REG_STAGES) check_outs($sformatf("post_rst c%0d", c), 0, 1, 5, 1, 1);
         else                     check_outs($sformatf("post_rst c%0d", c), 0, 0, 0, 0, 1);
         cycle_end();
      end

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].st, tbl[i].iv, int'(tbl[i].ird), tbl[i].fl,
               int'(tbl[i].rs1), tbl[i].u1, int'(tbl[i].rs2), tbl[i].u2);
         @(negedge clk);
         check_outs($sformatf("vec%0d", i), tbl[i].hz, tbl[i].wv, int'(tbl[i].wrd),
                    tbl[i].we, tbl[i].busy);
         cycle_end();
      end

`ifdef MUL_PERF_CNT_EN
      chk("perf_issued", perf_mul_issued, 7);
      chk("perf_stall", perf_mul_stall, 7);
`endif

      // Reset asserted while a tag sits in MEM: it must never reach WB.
      drive(0, 1, 6, 0, 0, 0, 0, 0);
      cycle_end();
      drive(0, 0, 0, 0, 6, 1, 0, 0);
      @(negedge clk);
      check_outs("mid_rst pre", 1, 0, 0, 0, 1);
      #1 rst_n = 1'b0;
      #1;
      check_outs("mid_rst during", 0, 0, 0, 0, 0);
`ifdef MUL_PERF_CNT_EN
      chk("mid_rst perf_issued", perf_mul_issued, 0);
      chk("mid_rst perf_stall", perf_mul_stall, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle_end();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_outs($sformatf("mid_rst after c%0d", c), 0, 0, 0, 0, 0);
         cycle_end();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
